host_link_responder: RTL and testbench

HOST_LINK_RESPONDER -- requirements
Module: host_link_responder

---
 rtl/host_link_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_host_link_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/host_link_responder.sv
// Host link responder: answers mole-position bytes with a delayed 'H'.
// Optional auto-restart ('S' after 'R') is enabled by HOST_AUTO_RESTART_EN.
module host_link_responder #(
  parameter int unsigned REACT_CYCLES   = 50_000_000,
  parameter int unsigned RESTART_CYCLES = 200_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [2:0] mole_index,
  output logic       mole_valid,
  output logic [7:0] hits_sent,
  output logic [7:0] games_done,
  output logic       proto_error
);

  localparam int unsigned MAXC =
    (REACT_CYCLES > RESTART_CYCLES) ? REACT_CYCLES : RESTART_CYCLES;
  localparam int unsigned CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] REACT_LAST = CW'(REACT_CYCLES - 1);

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REACT   = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_TX = 3'd3,
    S_HOLD    = 3'd4
`ifdef HOST_AUTO_RESTART_EN
    ,S_RESTART = 3'd5
`endif
  } state_t;

`ifdef HOST_AUTO_RESTART_EN
  localparam logic [CW-1:0] RESTART_LAST = CW'(RESTART_CYCLES - 1);
  localparam logic [7:0]    CH_S         = 8'h53;
  localparam state_t        R_DEST       = S_RESTART;
`else
  localparam state_t        R_DEST       = S_IDLE;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_pend_mole;
  logic            r_pend_r;
  logic            r_wait_arm;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [2:0]      r_mole_index;
  logic            r_mole_valid;
  logic [7:0]      r_hits;
  logic [7:0]      r_games;
  logic            r_proto_err;

  logic            w_rx_v;
  logic            w_rx_mole;
  logic            w_rx_r;
  logic            w_rx_bad;
  logic            w_busy_st;
  logic            w_busy_next;
  logic            w_react_done;
  logic            w_restart_done;
  logic            w_wait_done;
  logic            w_pm;
  logic            w_pr;
  logic            w_cnt_run;
  logic            w_send_go;
  logic            w_load_h;
  logic            w_load_s;

  // Byte classification; bytes only count while enabled.
  always_comb begin
    w_rx_v    = rx_ready && enable;
    w_rx_mole = w_rx_v && (rx_data >= 8'h30) && (rx_data <= 8'h34);
    w_rx_r    = w_rx_v && (rx_data == CH_R);
    w_rx_bad  = w_rx_v && !w_rx_mole && !w_rx_r;
  end

  // Event decode shared by next-state and datapath.
  always_comb begin
    w_busy_st    = (r_state == S_SEND) || (r_state == S_WAIT_TX);
    w_react_done = (r_state == S_REACT) && (r_cnt == REACT_LAST);
`ifdef HOST_AUTO_RESTART_EN
    w_restart_done = (r_state == S_RESTART) && (r_cnt == RESTART_LAST);
`else
    w_restart_done = 1'b0;
`endif
    w_wait_done  = (r_state == S_WAIT_TX) && r_wait_arm && !tx_busy;
    w_pm = w_rx_mole || (r_pend_mole && !w_rx_r);
    w_pr = w_rx_r || (r_pend_r && !w_rx_mole);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a fresh byte always beats an expiring timer.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_SEND: begin
          if (!tx_busy) w_next = S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (w_wait_done) begin
            if (w_pm)                   w_next = S_REACT;
            else if (w_pr)              w_next = R_DEST;
            else if (r_tx_data == CH_H) w_next = S_HOLD;
            else                        w_next = S_IDLE;
          end
        end
        default: begin
          if (w_rx_mole)           w_next = S_REACT;
          else if (w_rx_r)         w_next = R_DEST;
          else if (w_react_done)   w_next = S_SEND;
          else if (w_restart_done) w_next = S_SEND;
        end
      endcase
    end
  end

  // Output/datapath strobes derived from state and next state.
  always_comb begin
    w_busy_next = (w_next == S_SEND) || (w_next == S_WAIT_TX);
    w_send_go   = enable && (r_state == S_SEND) && !tx_busy;
    w_load_h    = w_react_done && (w_next == S_SEND);
    w_load_s    = w_restart_done && (w_next == S_SEND);
    w_cnt_run   = enable && (r_state == w_next) && !w_rx_mole && !w_rx_r;
`ifdef HOST_AUTO_RESTART_EN
    w_cnt_run   = w_cnt_run &&
                  ((w_next == S_REACT) || (w_next == S_RESTART));
`else
    w_cnt_run   = w_cnt_run && (w_next == S_REACT);
`endif
  end

  // Delay counter shared by REACT and RESTART; held while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_cnt <= '0;
    else if (!enable)   r_cnt <= r_cnt;
    else if (w_cnt_run) r_cnt <= r_cnt + 1'b1;
    else                r_cnt <= '0;
  end

  // Bytes arriving mid-transmission are remembered until WAIT_TX ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_mole <= 1'b0;
      r_pend_r    <= 1'b0;
    end else if (!w_busy_next) begin
      r_pend_mole <= 1'b0;
      r_pend_r    <= 1'b0;
    end else if (w_rx_mole) begin
      r_pend_mole <= 1'b1;
      r_pend_r    <= 1'b0;
    end else if (w_rx_r) begin
      r_pend_mole <= 1'b0;
      r_pend_r    <= 1'b1;
    end
  end

  // Guard cycle so a stale tx_busy is not mistaken for completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_wait_arm <= 1'b0;
    else        r_wait_arm <= (r_state == S_WAIT_TX) && (w_next == S_WAIT_TX);
  end

  // Transmit request and the byte it carries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= w_send_go;
      if (w_load_h) r_tx_data <= CH_H;
`ifdef HOST_AUTO_RESTART_EN
      if (w_load_s) r_tx_data <= CH_S;
`endif
    end
  end

  // Mole tracking from received bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mole_index <= 3'd0;
      r_mole_valid <= 1'b0;
    end else if (w_rx_mole) begin
      r_mole_index <= rx_data[2:0];
      r_mole_valid <= 1'b1;
    end else if (w_rx_r) begin
      r_mole_valid <= 1'b0;
    end
  end

  // Saturating statistics counters and the protocol error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hits      <= 8'd0;
      r_games     <= 8'd0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_rx_bad;
      if (w_send_go && (r_tx_data == CH_H) && (r_hits != 8'hFF))
        r_hits <= r_hits + 8'd1;
      if (w_rx_r && (r_games != 8'hFF))
        r_games <= r_games + 8'd1;
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign mole_index  = r_mole_index;
  assign mole_valid  = r_mole_valid;
  assign hits_sent   = r_hits;
  assign games_done  = r_games;
  assign proto_error = r_proto_err;

endmodule

// File: tb/tb_host_link_responder.sv
// Directed bench for host_link_responder.
// REACT_CYCLES=4, RESTART_CYCLES=8; HOST_AUTO_RESTART_EN optional.
module tb_host_link_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] mole_index;
  logic       mole_valid;
  logic [7:0] hits_sent;
  logic [7:0] games_done;
  logic       proto_error;

  int n_chk  = 0;
  int n_fail = 0;

  host_link_responder #(
    .REACT_CYCLES  (4),
    .RESTART_CYCLES(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .mole_index (mole_index),
    .mole_valid (mole_valid),
    .hits_sent  (hits_sent),
    .games_done (games_done),
    .proto_error(proto_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_start(input int max, output int n);
    bit done;
    done = 1'b0;
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      if (!done) begin
        tick();
        if (tx_start === 1'b1) begin
          n = i;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic pulses(input int cyc, output int c);
    c = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (tx_start === 1'b1) c++;
    end
  endtask

  initial begin
    int n;
    int c;
    int tmo;
    int exp_s;
`ifdef HOST_AUTO_RESTART_EN
    exp_s = 1;
`else
    exp_s = 0;
`endif
    reset    = 1'b0;
    enable   = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    tx_busy  = 1'b0;
    tick();
    tick();
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_mole_index", 32'(mole_index), 0);
    chk("rst_mole_valid", 32'(mole_valid), 0);
    chk("rst_hits", 32'(hits_sent), 0);
    chk("rst_games", 32'(games_done), 0);
    chk("rst_proto", 32'(proto_error), 0);
    reset = 1'b1;
    tick();

    // Basic mole -> H after REACT_CYCLES+1
    send_byte(8'h32);
    chk("m2_index", 32'(mole_index), 2);
    chk("m2_valid", 32'(mole_valid), 1);
    wait_start(20, n);
    chk("m2_latency", n, 5);
    chk("m2_tx_data", 32'(tx_data), 32'h48);
    chk("m2_hits", 32'(hits_sent), 1);
    tick();
    chk("m2_pulse_one", 32'(tx_start), 0);
    pulses(12, c);
    chk("m2_hold_quiet", c, 0);

    // Second mole two cycles later replaces the first
    send_byte(8'h31);
    tick();
    send_byte(8'h33);
    wait_start(20, n);
    chk("m13_latency", n, 5);
    chk("m13_index", 32'(mole_index), 3);
    chk("m13_hits", 32'(hits_sent), 2);
    pulses(15, c);
    chk("m13_single", c, 0);

    // Transmitter busy delays tx_start
    tx_busy = 1'b1;
    send_byte(8'h30);
    pulses(20, c);
    chk("busy_wait", c, 0);
    tx_busy = 1'b0;
    tick();
    chk("busy_release_start", 32'(tx_start), 1);
    tx_busy = 1'b1;
    tick();
    tick();
    chk("busy_tx_data_stable", 32'(tx_data), 32'h48);
    chk("busy_pulse_one", 32'(tx_start), 0);
    tick();
    tx_busy = 1'b0;
    pulses(10, c);
    chk("busy_single", c, 0);
    chk("busy_hits", 32'(hits_sent), 3);

    // Unrecognised byte
    send_byte(8'h41);
    chk("proto_pulse", 32'(proto_error), 1);
    tick();
    chk("proto_clear", 32'(proto_error), 0);
    chk("proto_index", 32'(mole_index), 0);
    chk("proto_valid", 32'(mole_valid), 1);
    pulses(10, c);
    chk("proto_quiet", c, 0);

    // End of game
    send_byte(8'h52);
    chk("r_valid", 32'(mole_valid), 0);
    chk("r_games", 32'(games_done), 1);
`ifdef HOST_AUTO_RESTART_EN
    wait_start(20, n);
    chk("r_s_latency", n, 9);
    chk("r_s_data", 32'(tx_data), 32'h53);
    pulses(5, c);
    chk("r_s_single", c, 0);
`else
    pulses(15, c);
    chk("r_no_tx", c, 0);
`endif
    chk("r_hits", 32'(hits_sent), 3);

    // Mole byte arriving as REACT expires wins
    send_byte(8'h34);
    tick();
    tick();
    tick();
    send_byte(8'h31);
    wait_start(20, n);
    chk("race_latency", n, 5);
    chk("race_index", 32'(mole_index), 1);
    chk("race_hits", 32'(hits_sent), 4);

    // Mole byte during WAIT_TX is queued
    send_byte(8'h33);
    wait_start(20, n);
    chk("pend_latency", n, 6);
    chk("pend_index", 32'(mole_index), 3);
    chk("pend_hits", 32'(hits_sent), 5);

    // 'R' during WAIT_TX
    send_byte(8'h52);
    chk("rwait_games", 32'(games_done), 2);
    chk("rwait_valid", 32'(mole_valid), 0);
    pulses(15, c);
    chk("rwait_tx", c, exp_s);
    chk("rwait_hits", 32'(hits_sent), 5);

    // Disabled block ignores everything
    enable = 1'b0;
    send_byte(8'h32);
    chk("dis_index", 32'(mole_index), 3);
    chk("dis_valid", 32'(mole_valid), 0);
    send_byte(8'h41);
    chk("dis_proto", 32'(proto_error), 0);
    pulses(15, c);
    chk("dis_quiet", c, 0);
    chk("dis_games", 32'(games_done), 2);
    enable = 1'b1;
    tick();

    // Reset in WAIT_TX
    send_byte(8'h31);
    wait_start(20, n);
    chk("rstw_latency", n, 5);
    reset = 1'b0;
    #1;
    chk("rstw_tx_start", 32'(tx_start), 0);
    chk("rstw_tx_data", 32'(tx_data), 0);
    chk("rstw_index", 32'(mole_index), 0);
    chk("rstw_valid", 32'(mole_valid), 0);
    chk("rstw_hits", 32'(hits_sent), 0);
    chk("rstw_games", 32'(games_done), 0);
    @(negedge clock);
    reset = 1'b1;
    pulses(15, c);
    chk("rstw_quiet", c, 0);

    // Saturation of hits_sent
    tmo = 0;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h30);
      wait_start(20, n);
      if (n > 20) tmo++;
    end
    chk("sat_timeouts", tmo, 0);
    chk("sat_hits", 32'(hits_sent), 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
